// File: rtl/umips_mem_arbiter_if.sv
// Bus bundle between the umips pipeline ports (IF fetch, MEM load/store) and the
// shared single-port memory, as seen by umips_mem_arbiter.
interface umips_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              if_stall;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    logic              dm_stall;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ready, if_stall,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_rdata, dm_ready, dm_stall,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Pipeline ports plus memory, driving requests and read data.
    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ready, if_stall,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_rdata, dm_ready, dm_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/umips_mem_arbiter.sv
// Shares one single-port memory between the IF fetch port and the MEM load/store port
// through an IDLE/ISSUE/WAIT/DONE sequence. Define ARB_PERF_CNT_EN for stall-cycle counters.
module umips_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
`ifdef ARB_PERF_CNT_EN
    umips_mem_arbiter_if.slave bus,
    output logic [31:0]        perf_if_wait,
    output logic [31:0]        perf_dm_wait
`else
    umips_mem_arbiter_if.slave bus
`endif
);

    localparam int               CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic              grant_go;
    logic              grant_dm;
    logic              capture;

    logic              gnt_dm_q;
    logic              last_gnt_dm_q;
    logic [CNT_W-1:0]  wait_cnt_q;

    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              if_ready_q;
    logic              dm_ready_q;

    logic              if_stall;
    logic              dm_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_go = 1'b0;
        grant_dm = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    grant_go = 1'b1;
                    // On a tie the port that lost last time wins, so fetch cannot starve.
                    grant_dm = bus.dm_req && (!bus.if_req || !last_gnt_dm_q);
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Issue stage: latch the granted port's request; mem_en is high only during ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_dm_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q <= grant_go;
            mem_we_q <= grant_go && grant_dm && bus.dm_we;
            if (grant_go) begin
                gnt_dm_q    <= grant_dm;
                mem_addr_q  <= grant_dm ? bus.dm_addr : bus.if_addr;
                mem_wdata_q <= grant_dm ? bus.dm_wdata : '0;
            end
        end
    end

    // Wait stage: count down the memory latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            wait_cnt_q <= LAT_LOAD;
        end else if (state_q == WAIT && wait_cnt_q != '0) begin
            wait_cnt_q <= wait_cnt_q - CNT_W'(1);
        end
    end

    // Done stage: read data lands in the granted port's register; ready pulses for DONE only.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_rdata_q    <= '0;
            dm_rdata_q    <= '0;
            if_ready_q    <= 1'b0;
            dm_ready_q    <= 1'b0;
            last_gnt_dm_q <= 1'b0;
        end else begin
            if_ready_q <= capture && !gnt_dm_q;
            dm_ready_q <= capture && gnt_dm_q;
            if (capture) begin
                if (gnt_dm_q) begin
                    dm_rdata_q <= bus.mem_rdata;
                end else begin
                    if_rdata_q <= bus.mem_rdata;
                end
            end
            if (state_q == DONE) begin
                last_gnt_dm_q <= gnt_dm_q;
            end
        end
    end

    assign if_stall = bus.if_req && !if_ready_q;
    assign dm_stall = bus.dm_req && !dm_ready_q;

`ifdef ARB_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_wait <= '0;
            perf_dm_wait <= '0;
        end else begin
            if (if_stall) begin
                perf_if_wait <= sat_inc(perf_if_wait);
            end
            if (dm_stall) begin
                perf_dm_wait <= sat_inc(perf_dm_wait);
            end
        end
    end
`endif

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.if_stall  = if_stall;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.dm_stall  = dm_stall;

endmodule
